taxi_mii_phy_tx_sink: RTL

PHY-side receiver for the MAC's MII transmit interface, i.e. the far end of the MAC's mii_txd/mii_tx_en/mii_tx_er. It samples nibbles on the MII TX clock, checks the preamble and SFD, and assembles bytes low nibble first. The frame payload (destination MAC through FCS) is emitted as a byte stream with tlast and an error flag. It is used in PHY models, loopback fixtures and link bring-up logic next to the MII MAC.

---
 rtl/taxi_mii_phy_tx_sink.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/taxi_mii_phy_tx_sink.sv
// taxi_mii_phy_tx_sink: PHY-side sink for a MAC's MII transmit nibbles, emitting frame payload bytes.
// Define TAXI_MII_PHY_TX_SINK_FCS_CHECK_EN to add the CRC-32 FCS check and the stat_err_fcs port.
module taxi_mii_phy_tx_sink #(
    parameter int MIN_PRE_NIBBLES = 1,
    parameter int MAX_FRAME_LEN = 1522
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] mii_txd,
    input  logic       mii_tx_en,
    input  logic       mii_tx_er,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       stat_start_packet,
    output logic       stat_err_preamble,
    output logic       stat_err_runt,
    output logic       stat_err_odd,
    output logic       stat_err_oversize
`ifdef TAXI_MII_PHY_TX_SINK_FCS_CHECK_EN
    ,
    output logic       stat_err_fcs
`endif
);
    localparam logic [3:0] MIN_PRE = 4'(MIN_PRE_NIBBLES);
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);

    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

    state_t      state;
    logic        armed;
    logic [3:0]  pre_cnt;
    logic        phase;
    logic [3:0]  low;
    logic [7:0]  hold;
    logic [15:0] byte_cnt;
    logic        err;
    logic        trunc;
    logic        fcs_bad;
    logic        sof;

    assign sof = state == PRE && mii_tx_en && mii_txd == 4'hD && pre_cnt >= MIN_PRE;

`ifdef TAXI_MII_PHY_TX_SINK_FCS_CHECK_EN
    logic [31:0] crc;
    logic        byte_done;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    assign byte_done = state == DATA && mii_tx_en && phase;
    // Running over data plus FCS leaves the fixed CRC-32 residue when the FCS is right
    assign fcs_bad = crc != 32'hDEBB20E3 || byte_cnt < 16'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
            stat_err_fcs <= 1'b0;
        end else begin
            crc <= sof ? 32'hFFFFFFFF : byte_done ? crc_byte(crc, {mii_txd, low}) : crc;
            stat_err_fcs <= state == DATA && !mii_tx_en && byte_cnt != 16'd0 && fcs_bad;
        end
    end
`else
    assign fcs_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
            pre_cnt <= '0;
            phase <= 1'b0;
            low <= '0;
            hold <= '0;
            byte_cnt <= '0;
            err <= 1'b0;
            trunc <= 1'b0;
            m_axis_tdata <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast <= 1'b0;
            m_axis_tuser <= 1'b0;
            stat_start_packet <= 1'b0;
            stat_err_preamble <= 1'b0;
            stat_err_runt <= 1'b0;
            stat_err_odd <= 1'b0;
            stat_err_oversize <= 1'b0;
        end else begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast <= 1'b0;
            m_axis_tuser <= 1'b0;
            stat_start_packet <= 1'b0;
            stat_err_preamble <= 1'b0;
            stat_err_runt <= 1'b0;
            stat_err_odd <= 1'b0;
            stat_err_oversize <= 1'b0;
            // A frame may only start after tx_en has been seen low, so one in flight at reset release is ignored
            armed <= armed | !mii_tx_en;
            case (state)
                IDLE: begin
                    if (mii_tx_en && armed) begin
                        if (mii_txd == 4'h5) begin
                            state <= PRE;
                            pre_cnt <= 4'd1;
                        end else begin
                            stat_err_preamble <= 1'b1;
                            state <= DROP;
                        end
                    end
                end
                PRE: begin
                    if (!mii_tx_en) begin
                        stat_err_preamble <= 1'b1;
                        state <= IDLE;
                    end else if (mii_txd == 4'h5) begin
                        pre_cnt <= pre_cnt == 4'hF ? pre_cnt : pre_cnt + 4'd1;
                    end else if (sof) begin
                        stat_start_packet <= 1'b1;
                        state <= DATA;
                        phase <= 1'b0;
                        byte_cnt <= '0;
                        err <= 1'b0;
                    end else begin
                        stat_err_preamble <= 1'b1;
                        state <= DROP;
                    end
                end
                DATA: begin
                    if (!mii_tx_en) begin
                        if (byte_cnt != 16'd0) begin
                            m_axis_tdata <= hold;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast <= 1'b1;
                            m_axis_tuser <= err | phase | fcs_bad;
                        end
                        stat_err_odd <= phase;
                        stat_err_runt <= byte_cnt == 16'd0;
                        state <= IDLE;
                    end else begin
                        err <= err | mii_tx_er;
                        phase <= !phase;
                        if (!phase) begin
                            low <= mii_txd;
                        end else begin
                            hold <= {mii_txd, low};
                            byte_cnt <= byte_cnt + 16'd1;
                            if (byte_cnt != 16'd0) begin
                                m_axis_tdata <= hold;
                                m_axis_tvalid <= 1'b1;
                            end
                            if (byte_cnt + 16'd1 == MAX_LEN) begin
                                trunc <= 1'b1;
                                state <= DROP;
                            end
                        end
                    end
                end
                DROP: begin
                    // The byte that hit the length limit leaves as a flagged last byte
                    if (trunc) begin
                        m_axis_tdata <= hold;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast <= 1'b1;
                        m_axis_tuser <= 1'b1;
                        stat_err_oversize <= 1'b1;
                        trunc <= 1'b0;
                    end
                    if (!mii_tx_en) state <= IDLE;
                end
            endcase
        end
    end
endmodule
